// File: rtl/vscpu_pkg.sv
// Shared types and default widths for the VerySimpleCPU memory arbiter slice.
package vscpu_pkg;

    localparam int unsigned VSCPU_AW = 14;
    localparam int unsigned VSCPU_DW = 32;

    typedef enum logic [1:0] {
        OFFER = 2'd0,
        OWN   = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vscpu_mem_arbiter_if.sv
// Bundle of CPU-side port vectors and SRAM-side signals around the arbiter.
interface vscpu_mem_arbiter_if
    import vscpu_pkg::*;
#(
    parameter int unsigned NPORTS = 3,
    parameter int unsigned AW     = VSCPU_AW,
    parameter int unsigned DW     = VSCPU_DW
) ();

    localparam int unsigned PW = $clog2(NPORTS);

    logic [NPORTS-1:0]    port_en;
    logic [NPORTS-1:0]    p_req;
    logic [NPORTS-1:0]    p_we;
    logic [NPORTS*AW-1:0] p_addr;
    logic [NPORTS*DW-1:0] p_wdata;
    logic [NPORTS-1:0]    p_vld;
    logic [DW-1:0]        p_rdata;
    logic                 ram_en;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_rdata;
    logic [PW-1:0]        owner;
    logic                 busy;

    // Cores plus SRAM macro as seen from outside the arbiter.
    modport master (
        output port_en, p_req, p_we, p_addr, p_wdata, ram_rdata,
        input  p_vld, p_rdata, ram_en, ram_we, ram_addr, ram_wdata, owner, busy
    );

    modport slave (
        input  port_en, p_req, p_we, p_addr, p_wdata, ram_rdata,
        output p_vld, p_rdata, ram_en, ram_we, ram_addr, ram_wdata, owner, busy
    );

endinterface

// File: rtl/vscpu_rr_next.sv
// Finds the next enabled port index strictly after ptr, wrapping; returns ptr if none.
module vscpu_rr_next
    import vscpu_pkg::*;
#(
    parameter int unsigned NPORTS = 3
) (
    input  logic [$clog2(NPORTS)-1:0] ptr,
    input  logic [NPORTS-1:0]         en,
    output logic [$clog2(NPORTS)-1:0] nxt
);

    localparam int unsigned PW = $clog2(NPORTS);

    logic [31:0] idx;
    logic        found;

    // k == NPORTS lands back on ptr itself, so a lone enabled port selects itself.
    always_comb begin
        nxt   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            idx = (32'(ptr) + k) % NPORTS;
            if (!found && ((en & (NPORTS'(1) << idx)) != '0)) begin
                nxt   = PW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vscpu_mem_arbiter.sv
// Round-robin token arbiter sharing one single-port SRAM between VerySimpleCPU cores.
module vscpu_mem_arbiter
    import vscpu_pkg::*;
#(
    parameter int unsigned NPORTS   = 3,
    parameter int unsigned AW       = VSCPU_AW,
    parameter int unsigned DW       = VSCPU_DW,
    parameter int unsigned IDLE_REL = 2,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    vscpu_mem_arbiter_if.slave bus
);

    localparam int unsigned PW = $clog2(NPORTS);
    localparam int unsigned IW = $clog2(IDLE_REL + 1);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, ptr_nxt;
    logic [IW-1:0]     idle_q, idle_d;
    logic [HW-1:0]     hold_q, hold_d;

    logic [NPORTS-1:0] tok_mask;
    logic [NPORTS-1:0] vld;
    logic              en_ptr;
    logic              req_ptr;
    logic              we_ptr;
    logic [31:0]       addr_lo;
    logic [31:0]       wdata_lo;
    logic [AW-1:0]     addr_ptr;
    logic [DW-1:0]     wdata_ptr;

    vscpu_rr_next #(
        .NPORTS(NPORTS)
    ) u_rr_next (
        .ptr(ptr_q),
        .en (bus.port_en),
        .nxt(ptr_nxt)
    );

    // vld is gated by rst_n so the cores see zero the instant reset asserts.
    always_comb begin
        tok_mask  = NPORTS'(1) << ptr_q;
        en_ptr    = |(bus.port_en & tok_mask);
        vld       = '0;
        if (rst_n && (state_q == OFFER || state_q == OWN)) begin
            vld = bus.port_en & tok_mask;
        end
        req_ptr   = |(bus.p_req & vld);
        we_ptr    = |(bus.p_we & vld);
        addr_lo   = 32'(ptr_q) * AW;
        wdata_lo  = 32'(ptr_q) * DW;
        addr_ptr  = AW'(bus.p_addr >> addr_lo);
        wdata_ptr = DW'(bus.p_wdata >> wdata_lo);
    end

    assign bus.p_vld     = vld;
    assign bus.p_rdata   = bus.ram_rdata;
    assign bus.ram_en    = req_ptr;
    assign bus.ram_we    = req_ptr & we_ptr;
    assign bus.ram_addr  = req_ptr ? addr_ptr : '0;
    assign bus.ram_wdata = req_ptr ? wdata_ptr : '0;
    assign bus.owner     = ptr_q;
    assign bus.busy      = (state_q == OWN);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idle_d  = idle_q;
        hold_d  = hold_q;
        case (state_q)
            OFFER: begin
                if (req_ptr) begin
                    state_d = OWN;
                    idle_d  = '0;
                    hold_d  = HW'(1);
                end else begin
                    ptr_d = ptr_nxt;
                end
            end
            OWN: begin
                if (!en_ptr) begin
                    state_d = GAP;
                end else begin
                    if (req_ptr) begin
                        idle_d = '0;
                    end else if (idle_q != IW'(IDLE_REL)) begin
                        idle_d = idle_q + IW'(1);
                    end
                    if (hold_q != HW'(MAX_HOLD)) begin
                        hold_d = hold_q + HW'(1);
                    end
                    // A write ends the instruction; it still completes this cycle.
                    if ((req_ptr && we_ptr) || idle_d == IW'(IDLE_REL) ||
                        hold_d == HW'(MAX_HOLD)) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d = OFFER;
                ptr_d   = ptr_nxt;
            end
            default: begin
                state_d = GAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFFER;
            ptr_q   <= '0;
            idle_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_vscpu_mem_arbiter.sv
// Directed plus randomized bench for vscpu_mem_arbiter against a token-passing reference model.
module tb_vscpu_mem_arbiter;

    localparam int NP       = 3;
    localparam int AW       = 14;
    localparam int DW       = 32;
    localparam int IDLE_REL = 2;
    localparam int MAX_HOLD = 64;

    localparam int M_OFFER = 0;
    localparam int M_OWN   = 1;
    localparam int M_GAP   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vscpu_mem_arbiter_if #(.NPORTS(NP), .AW(AW), .DW(DW)) bus ();

    vscpu_mem_arbiter #(
        .NPORTS(NP), .AW(AW), .DW(DW), .IDLE_REL(IDLE_REL), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // SRAM macro model: 1-cycle read latency, read data held until next read.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q = '0;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) sram[bus.ram_addr] <= bus.ram_wdata;
            else            rdata_q <= sram[bus.ram_addr];
        end
    end
    assign bus.ram_rdata = rdata_q;

    // Reference model state
    logic [1:0]    m_tok;
    int            m_ph, m_idle, m_held;
    logic [DW-1:0] ref_mem [0:15];
    bit            ref_vld [0:15];
    logic [DW-1:0] exp_rd;
    bit            exp_rd_known;

    logic [2:0]    e_vld;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    int n_checks, n_pass, n_fail;
    logic [2:0] obs_vld;
    logic       obs_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] next_en(input logic [1:0] t, input logic [2:0] en);
        for (int k = 1; k <= NP; k++) begin
            int c;
            c = (int'(t) + k) % NP;
            if (en[c]) return 2'(c);
        end
        return t;
    endfunction

    function automatic void calc();
        logic offering;
        offering = rst_n && (m_ph != M_GAP) && bus.port_en[m_tok];
        e_vld    = offering ? (3'b001 << m_tok) : 3'b000;
        e_en     = offering && bus.p_req[m_tok];
        e_we     = e_en && bus.p_we[m_tok];
        e_addr   = e_en ? bus.p_addr[m_tok*AW +: AW] : '0;
        e_wdata  = e_en ? bus.p_wdata[m_tok*DW +: DW] : '0;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_tok = 2'd0; m_ph = M_OFFER; m_idle = 0; m_held = 0;
            return;
        end
        calc();
        if (e_en) begin
            if (e_we) begin
                ref_mem[e_addr[3:0]] = e_wdata;
                ref_vld[e_addr[3:0]] = 1'b1;
            end else begin
                exp_rd       = ref_mem[e_addr[3:0]];
                exp_rd_known = ref_vld[e_addr[3:0]];
            end
        end
        case (m_ph)
            M_OFFER: begin
                if (e_en) begin m_ph = M_OWN; m_idle = 0; m_held = 1; end
                else m_tok = next_en(m_tok, bus.port_en);
            end
            M_OWN: begin
                if (!bus.port_en[m_tok]) m_ph = M_GAP;
                else begin
                    m_idle = e_en ? 0 : m_idle + 1;
                    if (m_held < MAX_HOLD) m_held++;
                    if ((e_en && e_we) || m_idle >= IDLE_REL || m_held >= MAX_HOLD) m_ph = M_GAP;
                end
            end
            default: begin
                m_ph  = M_OFFER;
                m_tok = next_en(m_tok, bus.port_en);
            end
        endcase
    endtask

    // One cycle: inputs already set after a negedge; check, clock, advance model.
    task automatic step();
        #1;
        calc();
        chk("p_vld", bus.p_vld, e_vld);
        chk("ram_en", bus.ram_en, e_en);
        chk("ram_we", bus.ram_we, e_we);
        chk("ram_addr", bus.ram_addr, e_addr);
        chk("ram_wdata", bus.ram_wdata, e_wdata);
        chk("owner", bus.owner, m_tok);
        chk("busy", bus.busy, (rst_n && m_ph == M_OWN));
        chk("vld_onehot0", $onehot0(bus.p_vld), 1);
        if (exp_rd_known) chk("p_rdata", bus.p_rdata, exp_rd);
        obs_vld = bus.p_vld;
        obs_en  = bus.ram_en;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wait_tok(input logic [1:0] t);
        int n;
        n = 0;
        bus.p_req = '0;
        bus.p_we  = '0;
        while (!(m_ph == M_OFFER && m_tok == t && bus.port_en[t]) && n < 12) begin
            step();
            n++;
        end
        #1;
        chk("wait_tok", bus.p_vld, 3'b001 << t);
    endtask

    task automatic rand_ports(input int we_div);
        for (int p = 0; p < NP; p++) begin
            bus.p_req[p] = ($urandom_range(0, 3) != 0);
            bus.p_we[p]  = ($urandom_range(0, we_div - 1) == 0);
            bus.p_addr[p*AW +: AW]  = AW'($urandom_range(0, 15));
            bus.p_wdata[p*DW +: DW] = $urandom;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rot [4];
        bit req_pat [6];
        bit we_pat [6];
        int run, ens, other, anyen;
        bit inrun;

        rot     = '{3'b001, 3'b010, 3'b100, 3'b001};
        req_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        we_pat  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_checks = 0; n_pass = 0; n_fail = 0;
        m_tok = 2'd0; m_ph = M_OFFER; m_idle = 0; m_held = 0;
        exp_rd = '0; exp_rd_known = 1'b0;
        for (int a = 0; a < 16; a++) begin ref_vld[a] = 1'b0; ref_mem[a] = '0; end
        bus.port_en = 3'b111;
        bus.p_req   = 3'b111;
        bus.p_we    = 3'b111;
        bus.p_addr  = '1;
        bus.p_wdata = '1;
        rst_n = 1'b0;

        // Reset state with requests pending
        @(negedge clk); #1;
        chk("rst_p_vld", bus.p_vld, 0);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        bus.p_req = '0; bus.p_we = '0; bus.p_addr = '0; bus.p_wdata = '0;

        // Token rotation with no requests
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rotate", obs_vld, rot[i]);
        end

        // Preload every address through port 0 (each write releases)
        for (int a = 0; a < 16; a++) begin
            wait_tok(2'd0);
            bus.p_req = 3'b001; bus.p_we = 3'b001;
            bus.p_addr[0 +: AW]  = AW'(a);
            bus.p_wdata[0 +: DW] = $urandom;
            step();
        end

        // ADD-like instruction on port 1
        wait_tok(2'd1);
        run = 0; ens = 0;
        for (int i = 0; i < 6; i++) begin
            bus.p_req = req_pat[i] ? 3'b010 : 3'b000;
            bus.p_we  = we_pat[i] ? 3'b010 : 3'b000;
            bus.p_addr[AW +: AW]  = AW'($urandom_range(0, 15));
            bus.p_wdata[DW +: DW] = $urandom;
            step();
            if (obs_vld == 3'b010) run++;
            if (obs_en) ens++;
        end
        chk("add_hold_cycles", run, 6);
        chk("add_ram_en_pulses", ens, 4);
        bus.p_req = '0; bus.p_we = '0;
        step();
        chk("add_gap", obs_vld, 0);
        step();
        chk("add_next_owner", obs_vld, 3'b100);

        // Owner stops requesting: released after IDLE_REL idle cycles
        wait_tok(2'd2);
        run = 0;
        for (int i = 0; i < 4; i++) begin
            bus.p_req = (i == 0) ? 3'b100 : 3'b000;
            bus.p_addr[2*AW +: AW] = AW'($urandom_range(0, 15));
            step();
            if (obs_vld == 3'b100) run++;
        end
        chk("idle_hold_cycles", run, 3);
        step();
        chk("idle_next_owner", obs_vld, 3'b001);

        // Continuous reads hit the fairness cap
        wait_tok(2'd0);
        run = 0; inrun = 1'b1;
        bus.p_req = 3'b001; bus.p_we = '0;
        for (int i = 0; i < 70; i++) begin
            bus.p_addr[0 +: AW] = AW'($urandom_range(0, 15));
            step();
            if (inrun && obs_vld == 3'b001) run++;
            else inrun = 1'b0;
        end
        chk("max_hold_cycles", run, MAX_HOLD);

        // Randomized traffic from all three cores
        for (int i = 0; i < 1500; i++) begin
            bus.port_en = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b111;
            rand_ports(5);
            step();
        end
        bus.port_en = 3'b111; bus.p_req = '0; bus.p_we = '0;
        step(); step();
        for (int a = 0; a < 16; a++) begin
            if (ref_vld[a]) chk("mem_image", sram[a], ref_mem[a]);
        end

        // Only port 1 enabled
        bus.port_en = 3'b010;
        other = 0;
        for (int i = 0; i < 30; i++) begin
            rand_ports(4);
            step();
            other = other | int'(obs_vld & 3'b101);
        end
        chk("en010_only_port1", other, 0);
        bus.p_req = 3'b010; bus.p_we = '0;
        for (int n = 0; n < 12 && !(m_ph == M_OWN && m_tok == 2'd1); n++) step();
        bus.port_en = 3'b000;
        #1;
        chk("drop_vld", bus.p_vld, 0);
        chk("drop_ram_en", bus.ram_en, 0);
        step(); step();
        chk("drop_vld_next", obs_vld, 0);
        other = 0; anyen = 0;
        for (int i = 0; i < 10; i++) begin
            rand_ports(4);
            step();
            other = other | int'(obs_vld);
            anyen = anyen | int'(obs_en);
        end
        chk("en000_no_vld", other, 0);
        chk("en000_no_ram_en", anyen, 0);

        // Reset asserted in the middle of an owner's write
        bus.port_en = 3'b111;
        wait_tok(2'd2);
        bus.p_req = 3'b100; bus.p_we = '0;
        bus.p_addr[2*AW +: AW] = AW'($urandom_range(0, 15));
        step();
        bus.p_we = 3'b100;
        bus.p_addr[2*AW +: AW]  = AW'(7);
        bus.p_wdata[2*DW +: DW] = $urandom | 32'h1;
        #1;
        chk("pre_rst_ram_we", bus.ram_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p_vld", bus.p_vld, 0);
        chk("mid_rst_ram_en", bus.ram_en, 0);
        chk("mid_rst_ram_we", bus.ram_we, 0);
        chk("mid_rst_ram_addr", bus.ram_addr, 0);
        chk("mid_rst_ram_wdata", bus.ram_wdata, 0);
        chk("mid_rst_owner", bus.owner, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst_n = 1'b1;
        bus.p_req = '0; bus.p_we = '0;
        step();
        chk("post_rst_vld", obs_vld, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
